// File: rtl/acc_stream_16bit.sv
// acc_stream_16bit: streaming 16-bit accumulator with valid/ready handshakes.
// Each accepted operand is added into a running sum. Beats and carry-out
// events are counted with saturating counters. The beat flagged in_last
// closes the packet, and its result is held until the consumer takes it.
// Optional macro ACC_SATURATE_EN: a carry-out pins the sum at all-ones
// instead of letting it wrap.
module acc_stream_16bit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] carries_reg, carries_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] out_sum_reg;
    logic [CNT_W-1:0] out_carries_reg;
    logic [CNT_W-1:0] out_count_reg;

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] acc_added;
    logic [CNT_W-1:0] carries_added;
    logic [CNT_W-1:0] count_added;
    logic             load_out;

    // Datapath: the sum and counters a beat would produce if accepted now.
    always_comb begin
        sum_full = {1'b0, acc_reg} + {1'b0, in_data};
`ifdef ACC_SATURATE_EN
        // Once a carry occurs the sum is pinned at all-ones; any later
        // nonzero add carries again, so it stays pinned for the packet.
        acc_added = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
        acc_added = sum_full[WIDTH-1:0];
`endif
        carries_added = carries_reg;
        if (sum_full[WIDTH] && (carries_reg != CNT_MAX)) begin
            carries_added = carries_reg + CNT_ONE;
        end
        count_added = count_reg;
        if (count_reg != CNT_MAX) begin
            count_added = count_reg + CNT_ONE;
        end
    end

    // Next-state logic: accumulate in ACC, wait for the consumer in HOLD.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        carries_next = carries_reg;
        count_next   = count_reg;
        load_out     = 1'b0;
        case (state_reg)
            ST_ACC: begin
                if (in_valid) begin
                    acc_next     = acc_added;
                    carries_next = carries_added;
                    count_next   = count_added;
                    if (in_last) begin
                        load_out   = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_next     = '0;
                    carries_next = '0;
                    count_next   = '0;
                    state_next   = ST_ACC;
                end
            end
            default: begin
                state_next = ST_ACC;
            end
        endcase
    end

    // State and running accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_ACC;
            acc_reg     <= '0;
            carries_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            carries_reg <= carries_next;
            count_reg   <= count_next;
        end
    end

    // Result registers capture the updated totals on the closing beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum_reg     <= '0;
            out_carries_reg <= '0;
            out_count_reg   <= '0;
        end else if (load_out) begin
            out_sum_reg     <= acc_added;
            out_carries_reg <= carries_added;
            out_count_reg   <= count_added;
        end
    end

    // Handshake flags decode only the registered state.
    assign in_ready    = (state_reg == ST_ACC);
    assign out_valid   = (state_reg == ST_HOLD);
    assign out_sum     = out_sum_reg;
    assign out_carries = out_carries_reg;
    assign out_count   = out_count_reg;

endmodule

// File: tb/tb_acc_stream_16bit.sv
// Testbench for acc_stream_16bit: table-driven packets plus directed
// sequences for backpressure, long bubbly packets and mid-packet reset.
module tb_acc_stream_16bit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_carries;
    logic [7:0]  out_count;

    int checks = 0;
    int errors = 0;

    acc_stream_16bit #(.WIDTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carries(out_carries),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [15:0] exp_sum;
        logic [7:0]  exp_carries;
        logic [7:0]  exp_count;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the beat is accepted.
    task automatic send_beat(input logic [15:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Checks a pending result and completes its handshake in one cycle.
    task automatic get_result(input string name, input logic [15:0] es,
                              input logic [7:0] ec, input logic [7:0] en);
        $display("pkt %s: sum=0x%04h carries=%0d count=%0d valid=%0b",
                 name, out_sum, out_carries, out_count, out_valid);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_sum"}, {16'd0, out_sum}, {16'd0, es});
        chk({name, "_carries"}, {24'd0, out_carries}, {24'd0, ec});
        chk({name, "_count"}, {24'd0, out_count}, {24'd0, en});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 1'b0, 16'h0000, 8'd0, 8'd0};
        vecs[1]  = '{16'h0001, 1'b1, 16'h1235, 8'd0, 8'd2};
        vecs[2]  = '{16'hFFFF, 1'b0, 16'h0000, 8'd0, 8'd0};
`ifdef ACC_SATURATE_EN
        vecs[3]  = '{16'h0002, 1'b1, 16'hFFFF, 8'd1, 8'd2};
`else
        vecs[3]  = '{16'h0002, 1'b1, 16'h0001, 8'd1, 8'd2};
`endif
        vecs[4]  = '{16'h8000, 1'b0, 16'h0000, 8'd0, 8'd0};
        vecs[5]  = '{16'h8000, 1'b0, 16'h0000, 8'd0, 8'd0};
`ifdef ACC_SATURATE_EN
        vecs[6]  = '{16'h8000, 1'b1, 16'hFFFF, 8'd2, 8'd3};
`else
        vecs[6]  = '{16'h8000, 1'b1, 16'h8000, 8'd1, 8'd3};
`endif
        vecs[7]  = '{16'h0000, 1'b1, 16'h0000, 8'd0, 8'd1};
        vecs[8]  = '{16'hFFFF, 1'b0, 16'h0000, 8'd0, 8'd0};
        vecs[9]  = '{16'hFFFF, 1'b0, 16'h0000, 8'd0, 8'd0};
`ifdef ACC_SATURATE_EN
        vecs[10] = '{16'h0001, 1'b1, 16'hFFFF, 8'd2, 8'd3};
`else
        vecs[10] = '{16'h0001, 1'b1, 16'hFFFF, 8'd1, 8'd3};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
        chk("rst_out_carries", {24'd0, out_carries}, 32'd0);
        chk("rst_out_count", {24'd0, out_count}, 32'd0);

        // Table-driven packets.
        for (int i = 0; i < NVEC; i++) begin
            send_beat(vecs[i].data, vecs[i].last);
            if (vecs[i].last) begin
                get_result($sformatf("vec%0d", i), vecs[i].exp_sum,
                           vecs[i].exp_carries, vecs[i].exp_count);
            end else begin
                chk($sformatf("vec%0d_no_valid", i), {31'd0, out_valid}, 32'd0);
            end
        end

        // Backpressure: result held, upstream stalled, offered beat ignored.
        send_beat(16'hABCD, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            $display("bp cycle %0d: valid=%0b in_ready=%0b sum=0x%04h count=%0d",
                     c, out_valid, in_ready, out_sum, out_count);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum", {16'd0, out_sum}, 32'h0000ABCD);
            chk("bp_count", {24'd0, out_count}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("bp_release", 16'hABCD, 8'd0, 8'd1);
        // The stalled 0x1111 must not have leaked into the next packet.
        send_beat(16'h0002, 1'b1);
        get_result("bp_after", 16'h0002, 8'd0, 8'd1);

        // 300 beats of 1 with random bubbles: count saturates at 255.
        for (int b = 1; b <= 300; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(16'h0001, (b == 300));
        end
        get_result("bubbles", 16'h012C, 8'd0, 8'd255);

        // Reset in mid-packet discards the partial sum.
        send_beat(16'h0100, 1'b0);
        send_beat(16'h0200, 1'b0);
        rst = 1'b1;
        #1;
        $display("reset asserted: valid=%0b sum=0x%04h carries=%0d count=%0d",
                 out_valid, out_sum, out_carries, out_count);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, out_sum}, 32'd0);
        chk("midrst_carries", {24'd0, out_carries}, 32'd0);
        chk("midrst_count", {24'd0, out_count}, 32'd0);
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_sum_hold", {16'd0, out_sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_beat(16'h0005, 1'b1);
        get_result("after_rst", 16'h0005, 8'd0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
